// File: rtl/sqrt_share_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_share_pkg
// Shared types and constants for the square-root sharing controller:
//   state_t                 controller FSM states (IDLE, ISSUE, WAIT, DRAIN)
//   OPERAND_W / RESULT_W    operand and result widths of the sqrt datapath
//   DEFAULT_TIMEOUT_CYCLES  default watchdog limit (START high to DONE seen)
// -----------------------------------------------------------------------------
package sqrt_share_pkg;

  localparam int OPERAND_W              = 32;
  localparam int RESULT_W               = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage : sqrt_share_pkg

// File: rtl/sqrt_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// sqrt_share_ctrl_if
// Bus between the sharing controller and the single iterative sqrt unit.
//   sq_in    operand, held stable by the controller for the whole operation
//   sq_start START, high from issue until DONE is seen (or the job is dropped)
//   sq_done  DONE from the unit
//   sq_avail AVAILABLE from the unit, high when it can take a new operand
//   sq_out   result from the unit
// Modports: master = controller side, slave = sqrt unit side.
// -----------------------------------------------------------------------------
interface sqrt_share_ctrl_if;
  import sqrt_share_pkg::*;

  logic [OPERAND_W-1:0] sq_in;
  logic                 sq_start;
  logic                 sq_done;
  logic                 sq_avail;
  logic [RESULT_W-1:0]  sq_out;

  modport master (
    output sq_in, sq_start,
    input  sq_done, sq_avail, sq_out
  );

  modport slave (
    input  sq_in, sq_start,
    output sq_done, sq_avail, sq_out
  );

endinterface : sqrt_share_ctrl_if

// File: rtl/sqrt_share_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. The search starts at ptr+1
// (modulo NUM_REQ) so the requester named by ptr has the lowest priority.
//   req    request vector
//   ptr    index of the previous winner
//   grant  one-hot grant (all zero when req is all zero)
//   idx    index of the granted requester (0 when nothing is granted)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic found;
  int   cand;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default before any
    // conditional assignment; otherwise a path that skips it infers a latch.
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = ID_W'(cand);
      end
    end
  end

endmodule : rr_pick

// File: rtl/sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_share_ctrl
// Round-robin arbiter and sequencer sharing one iterative sqrt unit between
// NUM_REQ requesters. Accepts one operand at a time, runs the unit's
// START/DONE/AVAILABLE handshake and returns the result with a one-cycle
// resp_valid pulse tagged with the owner's index.
//
// Ports:
//   clk, rstn    clock; synchronous active-low reset
//   req_valid    per-requester operand valid
//   req_data     packed operands, requester i on [32i+31:32i]
//   req_ready    one-hot accept, only in IDLE while the unit is available
//   resp_valid   one-cycle result pulse
//   resp_id      owner of the result
//   resp_data    square-root result (0 on a watchdog abort)
//   resp_err     watchdog abort flag, qualified by resp_valid
//   busy         high whenever the controller is not IDLE
//   sq           sqrt unit bus (sq_in, sq_start, sq_done, sq_avail, sq_out)
//
// Optional feature macro: SQRT_SHARE_TIMEOUT_EN
//   Defined: a watchdog aborts a job when TIMEOUT_CYCLES pass with START high
//   and no DONE; the response then carries resp_err=1 and resp_data=0.
//   Undefined: no counter, resp_err tied 0, WAIT lasts until DONE.
// -----------------------------------------------------------------------------
module sqrt_share_ctrl
  import sqrt_share_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*OPERAND_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic [RESULT_W-1:0]           resp_data,
  output logic                          resp_err,
  output logic                          busy,
  sqrt_share_ctrl_if.master             sq
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 2)
  begin : g_param_check
    $error("sqrt_share_ctrl: unsupported NUM_REQ/ID_W/TIMEOUT_CYCLES");
  end

  state_t              state;
  state_t              next_state;
  logic [ID_W-1:0]     rr_ptr;      // previous winner, lowest priority next
  logic [ID_W-1:0]     id_q;        // owner of the job in flight
  logic [ID_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]  pick_grant;
  logic                accept;
  logic                timeout;
  logic                done_evt;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // The grant is already a subset of req_valid, so any ready bit is an accept.
  assign accept   = |req_ready;
  assign done_evt = (state == WAIT) && (sq.sq_done || timeout);
  assign busy     = (state != IDLE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    unique case (state)
      IDLE: begin
        if (sq.sq_avail) begin
          req_ready = pick_grant;
          if (|req_valid) next_state = ISSUE;
        end
      end
      ISSUE:   next_state = WAIT;
      WAIT:    if (done_evt) next_state = DRAIN;
      // DONE must drop before a new job, so a stale DONE is never mistaken
      // for completion of the next operand.
      DRAIN:   if (!sq.sq_done && sq.sq_avail) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      id_q       <= '0;
      sq.sq_in   <= '0;
      sq.sq_start<= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid  <= 1'b0;
      // START is raised at the accept edge and held through WAIT; it drops on
      // the edge that leaves WAIT.
      sq.sq_start <= (next_state == ISSUE) || (next_state == WAIT);
      if (accept) begin
        sq.sq_in <= req_data[pick_idx*OPERAND_W +: OPERAND_W];
        id_q     <= pick_idx;
        rr_ptr   <= pick_idx;
      end
      if (done_evt) begin
        resp_valid <= 1'b1;
        resp_id    <= id_q;
        resp_data  <= timeout ? '0 : sq.sq_out;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional watchdog
  // ---------------------------------------------------------------------------
`ifdef SQRT_SHARE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // wd_cnt is 0 in the first START-high cycle (ISSUE); the abort fires in the
  // TIMEOUT_CYCLES-th START-high cycle if DONE is still low.
  assign timeout = (state == WAIT) && !sq.sq_done &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wd_cnt   <= '0;
      resp_err <= 1'b0;
    end else begin
      wd_cnt   <= (state == ISSUE || state == WAIT) ? wd_cnt + 1'b1 : '0;
      resp_err <= timeout;
    end
  end
`else
  assign timeout  = 1'b0;
  assign resp_err = 1'b0;
`endif

endmodule : sqrt_share_ctrl

// File: tb/tb_sqrt_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_share_ctrl
// Bench for sqrt_share_ctrl with a behavioural sqrt unit, per-requester
// operand queues, an independent round-robin model and a response scoreboard.
// Timing: unit model updates on negedge, outputs sampled at negedge+3,
// requester inputs driven at posedge+1.
// -----------------------------------------------------------------------------
module tb_sqrt_share_ctrl;
  import sqrt_share_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int UNIT_LAT = 15;

  typedef struct {
    int          id;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic                         clk;
  logic                         rstn;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*OPERAND_W-1:0] req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         resp_valid;
  logic [ID_W-1:0]              resp_id;
  logic [RESULT_W-1:0]          resp_data;
  logic                         resp_err;
  logic                         busy;

  sqrt_share_ctrl_if sq_bus ();

  sqrt_share_ctrl #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .sq         (sq_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    longint r = 0;
    longint t;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= longint'(v)) r = t;
    end
    return r[15:0];
  endfunction

  function automatic int rr_model(input logic [NUM_REQ-1:0] v, input int p);
    int j;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (p + k) % NUM_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural sqrt unit
  // ---------------------------------------------------------------------------
  int   m_state = 0;   // 0 idle, 1 running, 2 done held
  int   m_cnt   = 0;
  logic stuck          = 1'b0;
  logic hold_avail_low = 1'b0;

  initial begin
    sq_bus.sq_done  = 1'b0;
    sq_bus.sq_avail = 1'b1;
    sq_bus.sq_out   = '0;
  end

  always @(negedge clk) begin
    case (m_state)
      0: begin
        sq_bus.sq_done  = 1'b0;
        sq_bus.sq_avail = !hold_avail_low;
        if (sq_bus.sq_start) begin
          m_state         = 1;
          m_cnt           = 0;
          sq_bus.sq_avail = 1'b0;
        end
      end
      1: begin
        if (!sq_bus.sq_start) m_state = 0;
        else begin
          m_cnt++;
          if (!stuck && m_cnt >= UNIT_LAT) begin
            sq_bus.sq_done = 1'b1;
            sq_bus.sq_out  = isqrt(sq_bus.sq_in);
            m_state        = 2;
          end
        end
      end
      default: begin
        if (!sq_bus.sq_start) begin
          sq_bus.sq_done = 1'b0;
          m_state        = 0;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Requester driver: each requester presents its queued operands in order and
  // holds valid/data until accepted.
  // ---------------------------------------------------------------------------
  logic [31:0]        op_tab [NUM_REQ][8];
  int                 posted [NUM_REQ];
  int                 issued [NUM_REQ];
  logic [NUM_REQ-1:0] acc_mask;
  int                 cyc = 0;

  always @(posedge clk) cyc++;

  task automatic send(input int i, input logic [31:0] op);
    op_tab[i][posted[i]] = op;
    posted[i]++;
  endtask

  function automatic logic pending();
    for (int i = 0; i < NUM_REQ; i++)
      if (issued[i] < posted[i]) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      posted[i] = 0;
      issued[i] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (acc_mask != 0) check("start_latency", {31'd0, sq_bus.sq_start}, 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_mask[i]) begin
          req_valid[i] = 1'b0;
          issued[i]++;
        end
        if (!req_valid[i] && issued[i] < posted[i]) begin
          req_data[i*OPERAND_W +: OPERAND_W] = op_tab[i][issued[i]];
          req_valid[i] = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor and scoreboard
  // ---------------------------------------------------------------------------
  exp_t        exp_q [$];
  int          glog  [$];
  logic [15:0] rlog  [$];
  logic        last_err = 1'b0;
  logic        expect_timeout = 1'b0;
  logic        prev_rv = 1'b0;
  int          tb_ptr = NUM_REQ - 1;
  int          acc_cyc = 0;
  logic [31:0] cur_op = '0;

  initial begin
    exp_t e;
    int   exp_idx;
    int   act_idx;
    acc_mask = '0;
    forever begin
      @(negedge clk);
      #3;
      acc_mask = '0;
      if (!rstn) begin
        // Reset abandons any job in flight: nothing more is expected.
        exp_q.delete();
        tb_ptr  = NUM_REQ - 1;
        prev_rv = 1'b0;
      end else begin
        if (busy) check("ready_outside_idle", {28'd0, req_ready}, 0);
        if ((req_valid & req_ready) != 0) begin
          exp_idx = rr_model(req_valid, tb_ptr);
          check("grant", {28'd0, req_ready}, 32'(1) << exp_idx);
          act_idx = -1;
          for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ready[i]) act_idx = i;
          glog.push_back(act_idx);
          cur_op = req_data[exp_idx*OPERAND_W +: OPERAND_W];
          e.id   = exp_idx;
          e.err  = expect_timeout;
          e.data = expect_timeout ? 16'd0 : isqrt(cur_op);
          exp_q.push_back(e);
          tb_ptr   = exp_idx;
          acc_mask = req_valid & req_ready;
          acc_cyc  = cyc;
        end
        if (m_state == 1) begin
          check("start_held", {31'd0, sq_bus.sq_start}, 1);
          check("sq_in_hold", sq_bus.sq_in, cur_op);
        end
        if (resp_valid) begin
          check("resp_single_pulse", {31'd0, prev_rv}, 0);
          if (exp_q.size() == 0) check("unexpected_resp", {31'd0, resp_valid}, 0);
          else begin
            e = exp_q.pop_front();
            check("resp_id", {30'd0, resp_id}, e.id);
            check("resp_data", {16'd0, resp_data}, {16'd0, e.data});
            check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            if (e.err) check("wd_latency", cyc - acc_cyc, 65);
            rlog.push_back(resp_data);
            last_err = resp_err;
          end
        end
        prev_rv = resp_valid;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Test sequence (runs at negedge+1)
  // ---------------------------------------------------------------------------
  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || req_valid != 0 || busy || pending()) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", {31'd0, n < max_cyc}, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    int g0;
    int r0;
    int n;
    rstn = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check("rst_req_ready", {28'd0, req_ready}, 0);
    check("rst_resp_valid", {31'd0, resp_valid}, 0);
    check("rst_resp_err", {31'd0, resp_err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_sq_start", {31'd0, sq_bus.sq_start}, 0);
    check("rst_sq_in", sq_bus.sq_in, 0);
    check("rst_resp_data", {16'd0, resp_data}, 0);
    check("rst_resp_id", {30'd0, resp_id}, 0);
    @(negedge clk);
    #1;
    rstn = 1'b1;

    // Single request from requester 2
    g0 = glog.size();
    r0 = rlog.size();
    send(2, 32'd144);
    wait_idle(200);
    check("t1_grants", glog.size() - g0, 1);
    check("t1_id", (glog.size() > g0) ? glog[g0] : 99, 2);
    check("t1_data", (rlog.size() > r0) ? {16'd0, rlog[r0]} : 32'hdead, 12);

    // All four at once after reset: served 0,1,2,3
    do_reset();
    g0 = glog.size();
    r0 = rlog.size();
    send(0, 32'd16);
    send(1, 32'd25);
    send(2, 32'd36);
    send(3, 32'd49);
    wait_idle(400);
    check("t2_count", rlog.size() - r0, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_id%0d", k), (glog.size() > g0 + k) ? glog[g0+k] : 99, k);
      check($sformatf("t2_data%0d", k), (rlog.size() > r0 + k) ? {16'd0, rlog[r0+k]} : 32'hdead, 4 + k);
    end

    // Requester 0 re-requests continuously while requester 3 waits
    do_reset();
    g0 = glog.size();
    send(0, 32'd100);
    send(0, 32'd121);
    send(3, 32'd400);
    send(3, 32'd441);
    wait_idle(400);
    check("t3_count", glog.size() - g0, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t3_order%0d", k), (glog.size() > g0 + k) ? glog[g0+k] : 99, (k % 2 == 0) ? 0 : 3);

    // Unit unavailable: no ready until AVAILABLE rises
    hold_avail_low = 1'b1;
    @(negedge clk);
    #1;
    g0 = glog.size();
    send(1, 32'd169);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #3;
      check("t4_no_ready", {28'd0, req_ready}, 0);
    end
    @(negedge clk);
    #1;
    hold_avail_low = 1'b0;
    wait_idle(200);
    check("t4_served", (glog.size() > g0) ? glog[g0] : 99, 1);

    // Reset during WAIT: job dropped, pointer back to NUM_REQ-1
    send(1, 32'd225);
    n = 0;
    while (m_state != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t5_reached_wait", m_state, 1);
    repeat (3) @(negedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    #3;
    check("t5_sq_start", {31'd0, sq_bus.sq_start}, 0);
    check("t5_resp_valid", {31'd0, resp_valid}, 0);
    check("t5_busy", {31'd0, busy}, 0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    r0 = rlog.size();
    repeat (25) @(negedge clk);
    #1;
    check("t5_no_resp", rlog.size() - r0, 0);
    g0 = glog.size();
    send(0, 32'd256);
    send(3, 32'd289);
    wait_idle(300);
    check("t5_first_after_rst", (glog.size() > g0) ? glog[g0] : 99, 0);

`ifdef SQRT_SHARE_TIMEOUT_EN
    // Stuck unit: watchdog abort after 64 START-high cycles
    stuck          = 1'b1;
    expect_timeout = 1'b1;
    r0 = rlog.size();
    send(2, 32'd81);
    wait_idle(300);
    check("t6_resp", rlog.size() - r0, 1);
    check("t6_data", (rlog.size() > r0) ? {16'd0, rlog[r0]} : 32'hdead, 0);
    check("t6_err", {31'd0, last_err}, 1);
    check("t6_idle", {31'd0, busy}, 0);
    stuck          = 1'b0;
    expect_timeout = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in 200000 time units");
    $fatal(1);
  end

endmodule : tb_sqrt_share_ctrl

// File: doc/sqrt_share_ctrl.md
Name: sqrt_share_ctrl

Overview:
- Round-robin arbiter and sequencer that shares one iterative square-root unit between NUM_REQ requesters.
- The controller drives the unit's START/DONE/AVAILABLE handshake and holds the operand stable for the whole operation.
- It returns the 16-bit result to the granted requester with a one-cycle valid pulse and an id tag.
- Sits between accelerator clients and the single sqrt datapath instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must be at least clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles from START high to DONE seen (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*32  packed operands; requester i uses bits [32i+31:32i].
- req_ready  out  NUM_REQ  one-hot accept; an operand is accepted when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  1  one-cycle result pulse.
- resp_id  out  ID_W  index of the requester that owns the result.
- resp_data  out  16  square-root result.
- resp_err  out  1  watchdog abort flag, qualified by resp_valid.
- busy  out  1  high whenever the state is not IDLE.
- sq_in  out  32  operand to the sqrt unit.
- sq_start  out  1  START to the sqrt unit.
- sq_done  in  1  DONE from the sqrt unit.
- sq_avail  in  1  AVAILABLE from the sqrt unit.
- sq_out  in  16  result from the sqrt unit.

Behaviour:
- Reset (rstn low at a posedge):
  - State goes to IDLE.
  - req_ready, resp_valid, resp_err, busy, sq_start are 0; sq_in, resp_data, resp_id are 0.
  - Round-robin pointer set to NUM_REQ-1, so requester 0 wins first.
  - Reset mid-operation abandons the job with no response. The sqrt unit recovers on its own once sq_start is low.
- States:
  - IDLE:
    - req_ready is asserted combinationally, one-hot, to the round-robin winner among req_valid, only when sq_avail is 1.
    - On accept: latch the operand into sq_in, latch the winner into an id register, update the pointer to the winner, go to ISSUE.
    - If no request or sq_avail is 0, stay in IDLE.
  - ISSUE: sq_start goes high (registered), go to WAIT.
  - WAIT:
    - sq_start and sq_in are held.
    - When sq_done is sampled 1: capture sq_out into resp_data, drive resp_id from the id register, pulse resp_valid for exactly 1 cycle, deassert sq_start, go to DRAIN.
  - DRAIN: wait for sq_done to be 0 and sq_avail to be 1, then go to IDLE.
- Arbitration:
  - Search starts at pointer+1 modulo NUM_REQ.
  - A requester that just won has lowest priority next round.
  - Valid-only requesters are never starved; the worst-case wait is NUM_REQ-1 operations.
- Handshake rules:
  - Requesters must hold req_valid and req_data until accepted.
  - req_ready is never asserted outside IDLE.
  - Simultaneous valids: exactly one is accepted per operation.
- Latency:
  - Accept at cycle T; sq_start is high from T+1.
  - resp_valid goes high on the cycle after the first sampled sq_done.
  - With the standard unit this is about 18 cycles after T.
- Backpressure: none on the response. Clients must sample the response when resp_valid is high.
- busy equals (state != IDLE).
- sq_done seen outside WAIT is ignored.

Optional Feature:
- Macro: SQRT_SHARE_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT_CYCLES elapse without sq_done, the controller drops sq_start, pulses resp_valid with resp_err=1, resp_data=0 and the latched resp_id, then goes to DRAIN.
- Without the macro: no counter is built, resp_err is tied 0, and WAIT lasts indefinitely.

Decomposition:
- Package sqrt_share_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, DRAIN);
  - the operand width (32) and result width (16) constants;
  - the default TIMEOUT_CYCLES constant.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: request vector and pointer. Outputs: one-hot grant and index.
  - Instantiated once.

Test Plan:
- Single request: requester 2 presents 144 → one accept; resp_valid with resp_id=2 and resp_data=12; sq_start stays high until sq_done.
- All four valid at once with operands 16, 25, 36, 49 → responses in order id 0, 1, 2, 3 with values 4, 5, 6, 7; exactly one resp_valid pulse per response.
- Requester 0 re-requests continuously while requester 3 waits → grant order 0, 3, 0, 3; requester 3 is served within 2 operations.
- sq_avail held 0 by the bench model in IDLE with requests pending → req_ready stays 0 until sq_avail rises.
- rstn low during WAIT → the next cycle shows sq_start=0, resp_valid=0 and busy=0, with no response emitted. The next request gives requester 0 priority.
- With SQRT_SHARE_TIMEOUT_EN and a stuck unit (sq_done never rises) → after 64 cycles, resp_valid=1, resp_err=1, resp_data=0; the controller returns to IDLE once sq_avail=1.
